i2s_frame_codec: RTL and testbench

- Parametrised successor to the team's fixed 24-bit I2S capture/loopback block.
- Receives a stereo serial audio stream in Philips I2S or left-justified format, with configurable sample width and slot length.
- Presents committed left/right words with a valid strobe, per-channel parity and error flags.
- Retransmits the previous frame on sd_out with optional channel swap and mute; sits between the pad-level serial pins and the test/status outputs.

---
 rtl/i2s_frame_codec.sv | 203 ++++++++++++++++++++
 tb/tb_i2s_frame_codec.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_frame_codec.sv
// -----------------------------------------------------------------------------
// i2s_frame_codec
//
// Stereo serial audio receiver with loopback retransmit.
//
// RX (posedge sck): captures up to WIDTH bits per slot, MSB first, in Philips
// I2S (mode=0) or left-justified (mode=1) framing. A word is committed to
// rx_left/rx_right when ws changes. A slot that delivered fewer than WIDTH
// bits sets the sticky short_err flag.
//
// TX (negedge sck): at the start of every slot the shifter is loaded with the
// word most recently committed for that slot's channel. swap exchanges the
// channels and mute forces zeros. The output always uses Philips timing: the
// MSB is valid at the first posedge after the one that saw the ws change.
//
// rx_valid is a one-cycle strobe with no backpressure. A consumer that needs
// the word must take rx_left/rx_right (selected by rx_chan) in the cycle
// where rx_valid is high, or in any later cycle before the next commit to
// that channel.
//
// Ports:
//   sck           bit clock
//   reset         asynchronous, active-low reset
//   ws            word select (0 = left slot, 1 = right slot)
//   sd            serial data in
//   mode          0 = Philips I2S, 1 = left-justified; sampled at ws edges
//   swap          TX sends the right word in the left slot and vice versa
//   mute          TX sends all-zero words
//   clear         synchronous clear of short_err
//   sd_out        serial data out
//   rx_left       last committed left word
//   rx_right      last committed right word
//   rx_valid      one-cycle pulse on commit
//   rx_chan       channel of the most recent commit (0 = left)
//   parity_left   XOR-reduce of rx_left
//   parity_right  XOR-reduce of rx_right
//   synced        first ws edge since reset has been seen
//   short_err     sticky: a committed slot had fewer than WIDTH bits
//
// WIDTH must stay below 2**CNT_W so that the saturated position value can
// never alias a valid bit index.
// -----------------------------------------------------------------------------
module i2s_frame_codec #(
   parameter int WIDTH = 24,
   parameter int CNT_W = 6
) (
   input  logic             sck,
   input  logic             reset,
   input  logic             ws,
   input  logic             sd,
   input  logic             mode,
   input  logic             swap,
   input  logic             mute,
   input  logic             clear,
   output logic             sd_out,
   output logic [WIDTH-1:0] rx_left,
   output logic [WIDTH-1:0] rx_right,
   output logic             rx_valid,
   output logic             rx_chan,
   output logic             parity_left,
   output logic             parity_right,
   output logic             synced,
   output logic             short_err
);

   localparam logic [CNT_W-1:0] C_WIDTH    = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] C_WIDTH_M1 = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] C_POS_MAX  = '1;

   // RX state
   logic             r_ws_q;
   logic [CNT_W-1:0] r_pos;
   logic [WIDTH-1:0] r_word;
   logic [WIDTH-1:0] r_left;
   logic [WIDTH-1:0] r_right;
   logic             r_valid;
   logic             r_chan;
   logic             r_synced;
   logic             r_short;
   logic             r_tx_load;

   // TX state
   logic [WIDTH-1:0] r_tx;

   logic             w_edge;
   logic             w_commit;
   logic             w_short;
   logic [WIDTH-1:0] w_word_ins;
   logic [WIDTH-1:0] w_commit_word;
   logic [WIDTH-1:0] w_word_nxt;
   logic [CNT_W-1:0] w_pos_inc;
   logic [CNT_W-1:0] w_pos_nxt;
   logic [WIDTH-1:0] w_tx_load_val;

   assign w_edge   = ws ^ r_ws_q;
   assign w_commit = w_edge & r_synced;

   // Current word with the bit sampled now inserted at position r_pos.
   // Positions at or beyond WIDTH (including the saturated value) match no
   // bit index, so those bits are dropped.
   always_comb begin
      w_word_ins = r_word;
      for (int i = 0; i < WIDTH; i++) begin
         if (r_pos == CNT_W'(WIDTH - 1 - i)) begin
            w_word_ins[i] = sd;
         end
      end
   end

   assign w_pos_inc = (r_pos == C_POS_MAX) ? r_pos : r_pos + CNT_W'(1);

   // In Philips mode the bit at the edge still belongs to the old slot, so
   // the received count is r_pos + 1; in left-justified mode it is r_pos.
   assign w_commit_word = mode ? r_word : w_word_ins;
   assign w_short       = mode ? (r_pos < C_WIDTH) : (r_pos < C_WIDTH_M1);

   always_comb begin
      w_word_nxt = w_word_ins;
      w_pos_nxt  = w_pos_inc;
      if (w_edge) begin
         if (mode) begin
            // Left-justified: the edge bit is already the new word's MSB.
            w_word_nxt = {sd, {(WIDTH-1){1'b0}}};
            w_pos_nxt  = CNT_W'(1);
         end else begin
            w_word_nxt = '0;
            w_pos_nxt  = '0;
         end
      end
   end

   always_ff @(posedge sck or negedge reset) begin
      if (!reset) begin
         r_ws_q    <= 1'b0;
         r_pos     <= '0;
         r_word    <= '0;
         r_left    <= '0;
         r_right   <= '0;
         r_valid   <= 1'b0;
         r_chan    <= 1'b0;
         r_synced  <= 1'b0;
         r_short   <= 1'b0;
         r_tx_load <= 1'b0;
      end else begin
         r_ws_q    <= ws;
         r_word    <= w_word_nxt;
         r_pos     <= w_pos_nxt;
         r_valid   <= w_commit;
         r_tx_load <= w_edge;
         if (w_edge) begin
            r_synced <= 1'b1;
         end
         if (w_commit) begin
            r_chan <= r_ws_q;
            if (r_ws_q) begin
               r_right <= w_commit_word;
            end else begin
               r_left <= w_commit_word;
            end
         end
         // A short commit in the same cycle as clear keeps the flag set.
         if (w_commit && w_short) begin
            r_short <= 1'b1;
         end else if (clear) begin
            r_short <= 1'b0;
         end
      end
   end

   // r_ws_q already holds the new slot's channel by the load negedge, and
   // r_left/r_right already include any commit made at that posedge.
   always_comb begin
      w_tx_load_val = '0;
      if (!mute) begin
         if (r_ws_q) begin
            w_tx_load_val = swap ? r_left : r_right;
         end else begin
            w_tx_load_val = swap ? r_right : r_left;
         end
      end
   end

   always_ff @(negedge sck or negedge reset) begin
      if (!reset) begin
         r_tx <= '0;
      end else if (r_tx_load) begin
         r_tx <= w_tx_load_val;
      end else begin
         r_tx <= {r_tx[WIDTH-2:0], 1'b0};
      end
   end

   assign sd_out       = r_tx[WIDTH-1];
   assign rx_left      = r_left;
   assign rx_right     = r_right;
   assign rx_valid     = r_valid;
   assign rx_chan      = r_chan;
   assign parity_left  = ^r_left;
   assign parity_right = ^r_right;
   assign synced       = r_synced;
   assign short_err    = r_short;

endmodule

// File: tb/tb_i2s_frame_codec.sv
// -----------------------------------------------------------------------------
// tb_i2s_frame_codec
//
// Directed bench: a table of whole-frame vectors with hand-computed results,
// followed by hand-written sequences for loopback, sticky error clearing and
// mid-slot reset. Slots are driven bit by bit; every posedge the bench
// predicts whether a commit happens and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_i2s_frame_codec;

  localparam int WIDTH = 24;
  localparam int CNT_W = 6;

  logic             sck   = 1'b0;
  logic             reset = 1'b0;
  logic             ws    = 1'b0;
  logic             sd    = 1'b0;
  logic             mode  = 1'b0;
  logic             swap  = 1'b0;
  logic             mute  = 1'b0;
  logic             clear = 1'b0;
  logic             sd_out;
  logic [WIDTH-1:0] rx_left;
  logic [WIDTH-1:0] rx_right;
  logic             rx_valid;
  logic             rx_chan;
  logic             parity_left;
  logic             parity_right;
  logic             synced;
  logic             short_err;

  i2s_frame_codec #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .sck          (sck),
    .reset        (reset),
    .ws           (ws),
    .sd           (sd),
    .mode         (mode),
    .swap         (swap),
    .mute         (mute),
    .clear        (clear),
    .sd_out       (sd_out),
    .rx_left      (rx_left),
    .rx_right     (rx_right),
    .rx_valid     (rx_valid),
    .rx_chan      (rx_chan),
    .parity_left  (parity_left),
    .parity_right (parity_right),
    .synced       (synced),
    .short_err    (short_err)
  );

  // clock / watchdog
  always #5 sck = ~sck;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // counters and scoreboard
  int checks = 0;
  int errors = 0;
  logic [WIDTH:0] exp_q[$];  // {chan, word}

  // reference model state
  logic             m_synced;
  logic             m_ws_prev;
  logic             m_short;
  logic [WIDTH-1:0] m_left;
  logic [WIDTH-1:0] m_right;
  logic             p_ch;
  logic [WIDTH-1:0] p_word;
  logic             p_short;
  logic             tx_chk = 1'b0;

  typedef struct {
    logic             m;
    int               slen;
    logic [WIDTH-1:0] l;
    logic [WIDTH-1:0] r;
    logic             fill;
    logic [WIDTH-1:0] el;
    logic [WIDTH-1:0] er;
    logic             epl;
    logic             epr;
    logic             esh;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word as received from a slot of slen bits: bits past slen are zero.
  function automatic logic [WIDTH-1:0] exp_rx(input logic [WIDTH-1:0] w, input int slen);
    logic [WIDTH-1:0] r;
    r = w;
    for (int j = 0; j < WIDTH; j++) begin
      if (j >= slen) r[WIDTH-1-j] = 1'b0;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_synced  = 1'b0;
    m_ws_prev = 1'b0;
    m_short   = 1'b0;
    m_left    = '0;
    m_right   = '0;
    p_ch      = 1'b0;
    p_word    = '0;
    p_short   = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_reset(input logic m);
    @(negedge sck);
    reset = 1'b0;
    ws    = 1'b0;
    sd    = 1'b0;
    mode  = m;
    clear = 1'b0;
    swap  = 1'b0;
    mute  = 1'b0;
    repeat (2) @(negedge sck);
    reset = 1'b1;
    model_reset();
  endtask

  // Drive one slot of channel ch. In Philips mode ws moves to nxt on the
  // slot's last bit; in left-justified mode ws equals ch for the whole slot.
  task automatic send_slot(input logic m, input logic ch, input logic [WIDTH-1:0] w,
                           input int slen, input logic nxt, input logic fill);
    logic [WIDTH-1:0] word_e;
    logic [WIDTH-1:0] tx_e;
    logic [WIDTH-1:0] com_w;
    logic [WIDTH:0]   got;
    logic             ws_v;
    logic             sd_v;
    logic             com_v;
    logic             com_ch;
    logic             com_s;
    word_e = exp_rx(w, slen);
    if (mute) tx_e = '0;
    else if (!ch) tx_e = swap ? m_right : m_left;
    else tx_e = swap ? m_left : m_right;
    for (int i = 0; i < slen; i++) begin
      ws_v = (!m && i == slen - 1) ? nxt : ch;
      sd_v = (i < WIDTH) ? w[WIDTH-1-i] : fill;
      @(negedge sck);
      ws = ws_v;
      sd = sd_v;
      @(posedge sck);
      #1;
      com_v  = 1'b0;
      com_ch = 1'b0;
      com_w  = '0;
      com_s  = 1'b0;
      if (ws_v != m_ws_prev) begin
        if (!m_synced) begin
          m_synced = 1'b1;
        end else begin
          com_v = 1'b1;
          if (!m) begin
            com_ch = ch;
            com_w  = word_e;
            com_s  = (slen < WIDTH);
          end else begin
            com_ch = p_ch;
            com_w  = p_word;
            com_s  = p_short;
          end
        end
      end
      m_ws_prev = ws_v;
      if (com_v) begin
        exp_q.push_back({com_ch, com_w});
        if (com_ch) m_right = com_w;
        else m_left = com_w;
      end
      if (com_v && com_s) m_short = 1'b1;
      else if (clear) m_short = 1'b0;
      chk("rx_valid", rx_valid, com_v);
      if (com_v) begin
        got = exp_q.pop_front();
        chk("rx_chan", rx_chan, got[WIDTH]);
        chk("rx_word", got[WIDTH] ? rx_right : rx_left, got[WIDTH-1:0]);
        chk("parity", got[WIDTH] ? parity_right : parity_left, ^got[WIDTH-1:0]);
      end
      chk("short_err", short_err, m_short);
      if (tx_chk && !m) begin
        chk("sd_out", sd_out, (i < WIDTH) ? tx_e[WIDTH-1-i] : 1'b0);
      end
    end
    if (m) begin
      p_ch    = ch;
      p_word  = word_e;
      p_short = (slen < WIDTH);
    end
    chk("synced", synced, m_synced);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rx_left"}, rx_left, 0);
    chk({tag, "_rx_right"}, rx_right, 0);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_rx_chan"}, rx_chan, 0);
    chk({tag, "_parity_left"}, parity_left, 0);
    chk({tag, "_parity_right"}, parity_right, 0);
    chk({tag, "_synced"}, synced, 0);
    chk({tag, "_short_err"}, short_err, 0);
    chk({tag, "_sd_out"}, sd_out, 0);
  endtask

  initial begin
    // Words are given MSB-aligned in a WIDTH-bit field; a 16-bit slot
    // carries the top 16 bits.
    vecs[0] = '{1'b0, 32, 24'hA5A5A5, 24'h000007, 1'b0, 24'hA5A5A5, 24'h000007, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 32, 24'hA5A5A5, 24'h000007, 1'b0, 24'hA5A5A5, 24'h000007, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 16, 24'hABCD00, 24'h123400, 1'b0, 24'hABCD00, 24'h123400, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 40, 24'h123456, 24'h654321, 1'b1, 24'h123456, 24'h654321, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 16, 24'hFFFF00, 24'h000100, 1'b0, 24'hFFFF00, 24'h000100, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 70, 24'h0F0F0F, 24'h00FF00, 1'b1, 24'h0F0F0F, 24'h00FF00, 1'b0, 1'b0, 1'b0};

    // reset state
    model_reset();
    repeat (2) @(negedge sck);
    chk_all_zero("reset");
    reset = 1'b1;

    // table-driven frames
    for (int v = 0; v < 6; v++) begin
      do_reset(vecs[v].m);
      send_slot(vecs[v].m, 1'b0, '0,        vecs[v].slen, 1'b1, vecs[v].fill);
      send_slot(vecs[v].m, 1'b1, '0,        vecs[v].slen, 1'b0, vecs[v].fill);
      send_slot(vecs[v].m, 1'b0, vecs[v].l, vecs[v].slen, 1'b1, vecs[v].fill);
      send_slot(vecs[v].m, 1'b1, vecs[v].r, vecs[v].slen, 1'b0, vecs[v].fill);
      if (vecs[v].m) send_slot(1'b1, 1'b0, '0, vecs[v].slen, 1'b1, vecs[v].fill);
      chk($sformatf("vec%0d_rx_left", v), rx_left, vecs[v].el);
      chk($sformatf("vec%0d_rx_right", v), rx_right, vecs[v].er);
      chk($sformatf("vec%0d_parity_left", v), parity_left, vecs[v].epl);
      chk($sformatf("vec%0d_parity_right", v), parity_right, vecs[v].epr);
      chk($sformatf("vec%0d_short_err", v), short_err, vecs[v].esh);
    end

    // loopback: plain, swapped, muted
    do_reset(1'b0);
    send_slot(1'b0, 1'b0, '0, 32, 1'b1, 1'b0);
    send_slot(1'b0, 1'b1, '0, 32, 1'b0, 1'b0);
    tx_chk = 1'b1;
    send_slot(1'b0, 1'b0, 24'hA5A5A5, 32, 1'b1, 1'b0);
    send_slot(1'b0, 1'b1, 24'h000007, 32, 1'b0, 1'b0);
    send_slot(1'b0, 1'b0, 24'hA5A5A5, 32, 1'b1, 1'b0);
    send_slot(1'b0, 1'b1, 24'h000007, 32, 1'b0, 1'b0);
    swap = 1'b1;
    send_slot(1'b0, 1'b0, 24'h5A5A5A, 32, 1'b1, 1'b0);
    send_slot(1'b0, 1'b1, 24'h3C3C3C, 32, 1'b0, 1'b0);
    swap = 1'b0;
    mute = 1'b1;
    send_slot(1'b0, 1'b0, 24'hFFFFFF, 32, 1'b1, 1'b0);
    send_slot(1'b0, 1'b1, 24'hFFFFFF, 32, 1'b0, 1'b0);
    mute = 1'b0;
    tx_chk = 1'b0;

    // sticky short_err, clear, and set winning over clear
    do_reset(1'b0);
    send_slot(1'b0, 1'b0, '0,         16, 1'b1, 1'b0);
    send_slot(1'b0, 1'b1, 24'h00FF00, 16, 1'b0, 1'b0);
    send_slot(1'b0, 1'b0, 24'hABCD00, 16, 1'b1, 1'b0);
    chk("short_rx_left", rx_left, 24'hABCD00);
    chk("short_set", short_err, 1'b1);
    send_slot(1'b0, 1'b1, 24'h111111, 32, 1'b0, 1'b0);
    send_slot(1'b0, 1'b0, 24'h222222, 32, 1'b1, 1'b0);
    chk("short_sticky", short_err, 1'b1);
    clear = 1'b1;
    send_slot(1'b0, 1'b1, 24'h333333, 32, 1'b0, 1'b0);
    clear = 1'b0;
    chk("short_cleared", short_err, 1'b0);
    clear = 1'b1;
    send_slot(1'b0, 1'b0, 24'h444400, 16, 1'b1, 1'b0);
    clear = 1'b0;
    chk("short_set_beats_clear", short_err, 1'b1);

    // reset asserted mid-slot, away from any clock edge
    for (int i = 0; i < 5; i++) begin
      @(negedge sck);
      ws = 1'b1;
      sd = 1'b1;
    end
    @(posedge sck);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge sck);
    #1;
    chk_all_zero("midreset_neg");
    ws = 1'b0;
    sd = 1'b0;
    @(negedge sck);
    reset = 1'b1;
    model_reset();
    send_slot(1'b0, 1'b0, 24'h777777, 32, 1'b1, 1'b0);
    chk("post_reset_synced", synced, 1'b1);
    send_slot(1'b0, 1'b1, 24'h876543, 32, 1'b0, 1'b0);
    chk("post_reset_rx_right", rx_right, 24'h876543);
    send_slot(1'b0, 1'b0, 24'h0000F1, 32, 1'b1, 1'b0);
    chk("post_reset_rx_left", rx_left, 24'h0000F1);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
